// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the CPU's single memory address bus between the instruction-fetch
// path (requester A) and the data-access path (requester B). Each requester
// runs a req/gnt handshake with the arbiter. Ties are broken round-robin
// using the last owner. The arbiter also drives the select input of the 2:1
// address-bus mux.
//
// Optional feature: define ARB_HOLD_TIMEOUT_EN to compile in a hold timer.
// The timer revokes a grant after HOLD_MAX granted cycles and pulses
// 'timeout' for one cycle. With the macro undefined there is no timer, and
// 'timeout' is tied low.
//
// Parameters:
//   HOLD_MAX  maximum cycles a grant may be held when the timer is built
//             (legal range 2..255)
//
// Ports:
//   clk      rising-edge clock (the only clock domain)
//   rst      synchronous, active-high reset
//   req_a    request from the fetch path
//   req_b    request from the data path
//   done_a   owner A releases the bus (only looked at while gnt_a=1)
//   done_b   owner B releases the bus (only looked at while gnt_b=1)
//   gnt_a    registered grant to A
//   gnt_b    registered grant to B
//   sel      registered mux select, 0 = A drives the bus, 1 = B drives it
//   busy     high while either grant is high
//   timeout  one-cycle pulse when the hold timer revokes a grant
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic done_a,
   input  logic done_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic sel,
   output logic busy,
   output logic timeout
);

   // Reject an out-of-range HOLD_MAX at elaboration time.
   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_badHoldMax
      $error("mem_bus_arbiter: HOLD_MAX must be in 2..255");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } arbState_t;

   arbState_t r_state;
   logic      r_lastOwner;
   logic      r_gntA;
   logic      r_gntB;
   logic      r_sel;
   logic      r_busy;

   logic      w_relA;
   logic      w_relB;
   logic      w_pickA;

   // An owner gives the bus back either by pulsing done or by dropping
   // its request.
   assign w_relA = done_a | ~req_a;
   assign w_relB = done_b | ~req_b;

   // A wins when it asks alone, or when both ask and B owned the bus last.
   assign w_pickA = req_a & (~req_b | r_lastOwner);

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int              CntW    = $clog2(HOLD_MAX + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);
   localparam logic [CntW-1:0] CntSat  = '1;

   logic [CntW-1:0] r_holdCnt;
   logic            r_timeout;
   logic            w_holdExpired;

   // The counter starts at 0 in the first granted cycle. Reaching HOLD_MAX-1
   // therefore means this is the last cycle the grant may be held.
   assign w_holdExpired = (r_holdCnt == CntLast);
   assign timeout       = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   // The arbitration FSM is the only block here, and it registers every output.
   // Reset has priority over release, request and timeout. sel only changes on
   // entry into a grant state, so the bus mux never flips while the arbiter
   // is idle. A grant state always returns through IDLE, which gives the bus
   // a turnaround cycle between owners.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_gntA      <= 1'b0;
         r_gntB      <= 1'b0;
         r_sel       <= 1'b0;
         r_busy      <= 1'b0;
         r_lastOwner <= 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
         r_holdCnt   <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (req_a | req_b) begin
                  r_busy <= 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
                  r_holdCnt <= '0;
`endif
                  if (w_pickA) begin
                     r_state     <= GNT_A;
                     r_gntA      <= 1'b1;
                     r_sel       <= 1'b0;
                     r_lastOwner <= 1'b0;
                  end else begin
                     r_state     <= GNT_B;
                     r_gntB      <= 1'b1;
                     r_sel       <= 1'b1;
                     r_lastOwner <= 1'b1;
                  end
               end
            end

            GNT_A: begin
               if (w_relA) begin
                  r_state <= IDLE;
                  r_gntA  <= 1'b0;
                  r_busy  <= 1'b0;
               end
`ifdef ARB_HOLD_TIMEOUT_EN
               else if (w_holdExpired) begin
                  r_state   <= IDLE;
                  r_gntA    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
               end else if (r_holdCnt != CntSat) begin
                  r_holdCnt <= r_holdCnt + 1'b1;
               end
`endif
            end

            GNT_B: begin
               if (w_relB) begin
                  r_state <= IDLE;
                  r_gntB  <= 1'b0;
                  r_busy  <= 1'b0;
               end
`ifdef ARB_HOLD_TIMEOUT_EN
               else if (w_holdExpired) begin
                  r_state   <= IDLE;
                  r_gntB    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
               end else if (r_holdCnt != CntSat) begin
                  r_holdCnt <= r_holdCnt + 1'b1;
               end
`endif
            end

            default: begin
               r_state <= IDLE;
               r_gntA  <= 1'b0;
               r_gntB  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_a = r_gntA;
   assign gnt_b = r_gntB;
   assign sel   = r_sel;
   assign busy  = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter. The reference model tracks who
// owns the bus as a small integer and applies the arbitration rules
// directly. Every cycle, every DUT output is compared against that model.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int HOLD_MAX = 4;

   logic clk = 1'b0;
   logic rst, req_a, req_b, done_a, done_b;
   logic gnt_a, gnt_b, sel, busy, timeout;

   int total = 0;
   int bad   = 0;

   // Reference model state: owner 0 = nobody, 1 = A, 2 = B.
   int owner     = 0;
   int lastOwner = 2;
   int held      = 0;
   bit selExp    = 1'b0;
   bit toExp     = 1'b0;

   mem_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_a   (req_a),
      .req_b   (req_b),
      .done_a  (done_a),
      .done_b  (done_b),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   // Advance the reference model by one clock, using the inputs
   // that were sampled at that clock edge.
   task automatic modelStep(input bit ra, input bit rb, input bit da,
                            input bit db, input bit rs);
      bit released;
      toExp = 1'b0;
      if (rs) begin
         owner = 0; lastOwner = 2; selExp = 1'b0; held = 0;
      end else if (owner == 0) begin
         if (ra && (!rb || lastOwner == 2)) begin
            owner = 1; lastOwner = 1; selExp = 1'b0; held = 0;
         end else if (rb) begin
            owner = 2; lastOwner = 2; selExp = 1'b1; held = 0;
         end
      end else begin
         released = (owner == 1) ? (da || !ra) : (db || !rb);
         if (released) begin
            owner = 0;
         end else begin
            held = held + 1;
`ifdef ARB_HOLD_TIMEOUT_EN
            if (held >= HOLD_MAX) begin
               owner = 0;
               toExp = 1'b1;
            end
`endif
         end
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkBit("gnt_a",   gnt_a,   owner == 1);
      checkBit("gnt_b",   gnt_b,   owner == 2);
      checkBit("sel",     sel,     selExp);
      checkBit("busy",    busy,    owner != 0);
      checkBit("timeout", timeout, toExp);
      checkBit("mutex",   gnt_a & gnt_b, 1'b0);
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      total++;
      assert (obs == exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model and check outputs.
   task automatic applyStimulus(input bit ra, input bit rb, input bit da,
                                input bit db, input bit rs);
      req_a = ra; req_b = rb; done_a = da; done_b = db; rst = rs;
      @(posedge clk);
      modelStep(ra, rb, da, db, rs);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
   endtask

   int grantOrder[$];
   int bGrants;
   int runLen;
   bit prevA, prevB, inRun;

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;

      // Reset, then a single A transaction released by done_a.
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      checkBit("t1_gntA", gnt_a, 1'b1);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkBit("t1_release", gnt_a, 1'b0);
      checkBit("t1_selHeld", sel, 1'b0);
      applyStimulus(0, 0, 0, 0, 0);

      // Both requesters always asking; each owner releases at once.
      doReset();
      prevA = 1'b0; prevB = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 1, gnt_a, gnt_b, 0);
         if (gnt_a && !prevA) grantOrder.push_back(1);
         if (gnt_b && !prevB) grantOrder.push_back(2);
         prevA = gnt_a; prevB = gnt_b;
      end
      checkInt("t2_grantCount", grantOrder.size(), 3);
      if (grantOrder.size() == 3) begin
         checkInt("t2_first",  grantOrder[0], 1);
         checkInt("t2_second", grantOrder[1], 2);
         checkInt("t2_third",  grantOrder[2], 1);
      end

      // Only B asks, for three transactions in a row.
      doReset();
      bGrants = 0;
      for (int t = 0; t < 3; t++) begin
         applyStimulus(0, 1, 0, 0, 0);
         if (gnt_b) bGrants++;
         applyStimulus(0, 1, 0, 1, 0);
         checkBit("t3_selGap", sel, 1'b1);
         applyStimulus(0, 0, 0, 0, 0);
      end
      checkInt("t3_bGrants", bGrants, 3);

      // Reset in the second cycle of GNT_B, then a tie goes to A.
      doReset();
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 1);
      checkBit("t4_rstGntB", gnt_b, 1'b0);
      checkBit("t4_rstSel",  sel,   1'b0);
      applyStimulus(1, 1, 0, 0, 0);
      checkBit("t4_tieA", gnt_a, 1'b1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // B holds without releasing while A waits: measure the first B grant run.
      doReset();
      applyStimulus(0, 1, 0, 0, 0);
      runLen = gnt_b ? 1 : 0;
      inRun  = gnt_b;
      for (int i = 0; i < 51; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         if (inRun && gnt_b) runLen++;
         else inRun = 1'b0;
      end
`ifdef ARB_HOLD_TIMEOUT_EN
      checkInt("t5_holdLen", runLen, HOLD_MAX);
`else
      checkInt("t5_holdLen", runLen, 52);
`endif
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 49) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
